// File: rtl/uart_pkg.sv
// Shared types and constants for the UART datapath (transmit and future receive side).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

    // Transmit frame sequencer states; PARITY is only visited when parity is built in
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // 100 MHz core clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Level of an idle (marking) serial line; start bit is the inverse
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts CLKS_PER_BIT cycles per serial bit, restartable to align bit edges.
// Latency: bit_done is high on the last cycle of each bit; first bit ends CLKS_PER_BIT cycles after restart.
// Backpressure: none; counts every cycle that restart is low.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done,
    output logic bit_pre_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    // Count up within a bit, wrap at the bit boundary, and snap to zero on restart
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // bit_pre_done lets a consumer register a signal that lines up with bit_done
    assign bit_done     = (cnt == CNT_LAST);
    assign bit_pre_done = (cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// UART serializer: start bit, DLEN data bits LSB-first, optional even parity (UART_TX_PARITY_EN), STOP_BITS stop bits.
// Latency: start bit on the line the cycle after the i_valid/o_ready handshake; frame is (1+DLEN+P+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: o_ready only in IDLE and the final stop cycle, so held i_valid gives gap-free back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DLEN         = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [DLEN-1:0] i_data,
    output logic            o_tx,
    output logic            o_busy
);

    localparam int IDX_W = $clog2(DLEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DLEN - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e        state;
    tx_state_e        state_n;
    logic [DLEN-1:0]  shreg;
    logic [IDX_W-1:0] bit_idx;
    logic             stop_idx;
    logic             accept;
    logic             baud_restart;
    logic             bit_done;
    logic             bit_pre_done;
    logic             tx_d;
    logic             ready_d;
    logic             busy_d;
`ifdef UART_TX_PARITY_EN
    logic             par_bit;
`endif

    assign accept       = i_valid && o_ready;
    // Hold the bit timer at zero while idle so every frame starts on a fresh bit period
    assign baud_restart = accept || (state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk          (clk),
        .rst          (rst),
        .restart      (baud_restart),
        .bit_done     (bit_done),
        .bit_pre_done (bit_pre_done)
    );

    // State register plus the frame datapath: latch on accept, shift and count on bit boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                shreg    <= i_data;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_bit  <= ^i_data;
`endif
            end else if (bit_done) begin
                case (state)
                    DATA: begin
                        shreg   <= shreg >> 1;
                        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);
                    end
                    STOP: begin
                        stop_idx <= (stop_idx == STOP_LAST) ? 1'b0 : stop_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next-state sequencing; a byte accepted in the final stop cycle goes straight to START
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = START;
            START: if (bit_done) state_n = DATA;
            DATA: begin
                if (bit_done && (bit_idx == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_n = STOP;
`endif
            STOP: begin
                if (bit_done && (stop_idx == STOP_LAST)) begin
                    state_n = accept ? START : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from where the sequencer is heading
    always_comb begin
        tx_d    = UART_IDLE_LEVEL;
        busy_d  = (state_n != IDLE);
        // Ready must be visible during the final stop cycle, so it is set one cycle ahead
        ready_d = !accept &&
                  ((state_n == IDLE) ||
                   ((state == STOP) && (stop_idx == STOP_LAST) && bit_pre_done));
        case (state_n)
            START: tx_d = ~UART_IDLE_LEVEL;
            // Shift register moves on the same edge, so look one bit ahead when it does
            DATA:  tx_d = ((state == DATA) && bit_done) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = par_bit;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // Output registers; reset drives the line idle and withholds ready for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx    <= UART_IDLE_LEVEL;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_tx    <= tx_d;
            o_ready <= ready_d;
            o_busy  <= busy_d;
        end
    end

endmodule
